// File: rtl/hga_display_scanout.sv
// Programmable-timing VGA/RGB-LCD scanout: PCLK/HSYNC/VSYNC/DE generation fed from a pixel FIFO.
// Define HGA_SCANOUT_TESTPAT_EN to add the pat_en input and the built-in colour-bar generator.
module hga_display_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PCLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rsti,
  input  logic                 en,
  input  logic [3*COLOR_W-1:0] pix_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 frame_start,
  output logic                 underflow,
  input  logic                 underflow_clr,
`ifdef HGA_SCANOUT_TESTPAT_EN
  input  logic                 pat_en,
`endif
  output logic [COLOR_W-1:0]   VGAR,
  output logic [COLOR_W-1:0]   VGAG,
  output logic [COLOR_W-1:0]   VGAB,
  output logic                 PCLK,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic                 DE
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW      = $clog2(PCLK_DIV);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;
  localparam int PIX_W   = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FS_PRE = VW'(V_TOTAL - 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(PCLK_DIV / 2);
  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [HW-1:0]    h_cnt_q, h_cnt_d;
  logic [VW-1:0]    v_cnt_q, v_cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             pix_ready_q, pix_ready_d;
  logic             frame_start_q, frame_start_d;
  logic             underflow_q, underflow_d;
  logic             pclk_q, pclk_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [PIX_W-1:0] colour_q, colour_d;

  logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic             tick;
  logic             push;
  logic             fifo_empty;
  logic             active_pos;
  logic             uf_set;
  logic [PW-1:0]    fill_next;

`ifdef HGA_SCANOUT_TESTPAT_EN
  // Eight equal-width bars across the active line, each channel at full scale or zero.
  function automatic logic [PIX_W-1:0] bar_colour(input logic [HW-1:0] h);
    int         band;
    logic [2:0] rgb;
    band = (int'(h) * 8) / H_ACTIVE;
    case (band)
      0:       rgb = 3'b111;
      1:       rgb = 3'b110;
      2:       rgb = 3'b011;
      3:       rgb = 3'b010;
      4:       rgb = 3'b101;
      5:       rgb = 3'b100;
      6:       rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return {{COLOR_W{rgb[2]}}, {COLOR_W{rgb[1]}}, {COLOR_W{rgb[0]}}};
  endfunction
`endif

  assign tick       = (div_cnt_q == DIV_LAST);
  assign push       = pix_valid && pix_ready_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign active_pos = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);

  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pclk_d        = pclk_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    colour_d      = colour_q;
    frame_start_d = 1'b0;
    uf_set        = 1'b0;

    if (!en) begin
      div_cnt_d = '0;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      pclk_d    = 1'b0;
      hsync_d   = !HS_POL;
      vsync_d   = !VS_POL;
      de_d      = 1'b0;
      colour_d  = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      pclk_d    = (div_cnt_d < DIV_HALF);
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (tick) begin
        // Outputs are registered from the current position, then the position advances.
        hsync_d = ((int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                   (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : !HS_POL;
        vsync_d = ((int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                   (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : !VS_POL;
        de_d    = active_pos;
        colour_d = '0;
        if (active_pos) begin
`ifdef HGA_SCANOUT_TESTPAT_EN
          if (pat_en) begin
            colour_d = bar_colour(h_cnt_q);
          end else
`endif
          if (!fifo_empty) begin
            colour_d = fifo_mem[rd_ptr_q[AW-1:0]];
            rd_ptr_d = rd_ptr_q + 1'b1;
          end else begin
            uf_set = 1'b1;
          end
        end
        if (h_cnt_q == H_LAST) begin
          h_cnt_d       = '0;
          v_cnt_d       = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
          frame_start_d = (v_cnt_q == V_FS_PRE);
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
    end

    fill_next   = wr_ptr_d - rd_ptr_d;
    pix_ready_d = en && (fill_next != FULL_CNT);
    // A new underflow in the same cycle as a clear request keeps the flag set.
    underflow_d = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk or negedge rsti) begin
    if (!rsti) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pix_ready_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      pclk_q        <= 1'b0;
      hsync_q       <= !HS_POL;
      vsync_q       <= !VS_POL;
      de_q          <= 1'b0;
      colour_q      <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pix_ready_q   <= pix_ready_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      pclk_q        <= pclk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      colour_q      <= colour_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && en) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= pix_data;
    end
  end

  assign pix_ready   = pix_ready_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign PCLK        = pclk_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign VGAR        = colour_q[3*COLOR_W-1:2*COLOR_W];
  assign VGAG        = colour_q[2*COLOR_W-1:COLOR_W];
  assign VGAB        = colour_q[COLOR_W-1:0];

endmodule

// File: tb/tb_hga_display_scanout.sv
// Randomised scoreboard bench for hga_display_scanout on a tiny 7x5 raster.
module tb_hga_display_scanout;

  localparam int HA = 4, HFP = 1, HSY = 1, HBP = 1;
  localparam int VA = 2, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int DIV = 2;
  localparam int DEPTH = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic        pclk;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        rdy;
    logic        uf;
    logic [23:0] col;
  } exp_t;

  logic          clk = 1'b0;
  logic          rsti = 1'b1;
  logic          en = 1'b0;
  logic [23:0]   pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          underflow_clr = 1'b0;
  logic          pix_ready, frame_start, underflow;
  logic [CW-1:0] VGAR, VGAG, VGAB;
  logic          PCLK, HSYNC, VSYNC, DE;

  hga_display_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW),
    .FIFO_DEPTH(DEPTH), .PCLK_DIV(DIV)
  ) dut (
    .clk(clk), .rsti(rsti), .en(en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr),
    .VGAR(VGAR), .VGAG(VGAG), .VGAB(VGAB),
    .PCLK(PCLK), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_field(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: raster position is a plain tick index, the FIFO is a queue.
  int          mdiv = 0;
  int          mt = 0;
  int          mh, mv;
  bit          m_ready = 0, m_uf = 0, m_hs = 1, m_vs = 1, m_de = 0, m_fs = 0, m_pclk = 0;
  bit          uf_set, acc, is_tick;
  logic [23:0] m_col = '0;
  logic [23:0] pixq[$];
  exp_t        exp_q[$];
  exp_t        e;

  always @(posedge clk or negedge rsti) begin
    if (!rsti) begin
      mdiv = 0; mt = 0; pixq.delete();
      m_ready = 0; m_uf = 0; m_hs = 1; m_vs = 1; m_de = 0; m_fs = 0; m_pclk = 0; m_col = '0;
      exp_q.delete();
    end else if (!en) begin
      mdiv = 0; mt = 0; pixq.delete();
      m_ready = 0; m_hs = 1; m_vs = 1; m_de = 0; m_fs = 0; m_pclk = 0; m_col = '0;
      if (underflow_clr) m_uf = 0;
    end else begin
      acc = pix_valid && m_ready;
      is_tick = (mdiv == DIV - 1);
      uf_set = 0;
      m_fs = 0;
      if (is_tick) begin
        mh = mt % HT;
        mv = (mt / HT) % VT;
        m_hs = !((mh >= HA + HFP) && (mh < HA + HFP + HSY));
        m_vs = !((mv >= VA + VFP) && (mv < VA + VFP + VSY));
        m_de = (mh < HA) && (mv < VA);
        m_col = '0;
        if (m_de) begin
          if (pixq.size() > 0) m_col = pixq.pop_front();
          else uf_set = 1;
        end
        m_fs = (((mt + 1) % FRAME) == (VT - 1) * HT);
        mt++;
      end
      if (acc) pixq.push_back(pix_data);
      mdiv = is_tick ? 0 : mdiv + 1;
      m_pclk = (mdiv < DIV / 2);
      m_ready = (pixq.size() < DEPTH);
      if (uf_set) m_uf = 1;
      else if (underflow_clr) m_uf = 0;
    end
    e.pclk = m_pclk; e.hs = m_hs; e.vs = m_vs; e.de = m_de;
    e.fs = m_fs; e.rdy = m_ready; e.uf = m_uf; e.col = m_col;
    exp_q.push_back(e);
  end

  // Monitor: one expected tuple per cycle, compared on the falling edge.
  exp_t got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check_field("pclk", 24'(PCLK), 24'(got.pclk));
      check_field("hsync", 24'(HSYNC), 24'(got.hs));
      check_field("vsync", 24'(VSYNC), 24'(got.vs));
      check_field("de", 24'(DE), 24'(got.de));
      check_field("frame_start", 24'(frame_start), 24'(got.fs));
      check_field("pix_ready", 24'(pix_ready), 24'(got.rdy));
      check_field("underflow", 24'(underflow), 24'(got.uf));
      check_field("colour", {VGAR, VGAG, VGAB}, got.col);
    end
  end

  task automatic check_reset_values(input string tag);
    check_field({tag, "_pclk"}, 24'(PCLK), 24'd0);
    check_field({tag, "_hsync"}, 24'(HSYNC), 24'd1);
    check_field({tag, "_vsync"}, 24'(VSYNC), 24'd1);
    check_field({tag, "_de"}, 24'(DE), 24'd0);
    check_field({tag, "_ready"}, 24'(pix_ready), 24'd0);
    check_field({tag, "_fs"}, 24'(frame_start), 24'd0);
    check_field({tag, "_uf"}, 24'(underflow), 24'd0);
    check_field({tag, "_colour"}, {VGAR, VGAG, VGAB}, 24'd0);
  endtask

  task automatic drive_random(input int n, input int pct, input int clr_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid     = ($urandom_range(0, 99) < pct);
      pix_data      = 24'($urandom);
      underflow_clr = ($urandom_range(0, 99) < clr_pct);
    end
  endtask

  initial begin
    #1 rsti = 1'b0;
    #2 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rsti = 1'b1;
    en = 1'b1;
    // Starved frames, then clearing the sticky flag.
    drive_random(150, 0, 0);
    drive_random(20, 0, 100);
    // Mixed fill rates, from starving to saturating.
    drive_random(300, 8, 3);
    drive_random(300, 70, 3);
    // Scanout enable dropped at random points.
    for (int k = 0; k < 5; k++) begin
      drive_random($urandom_range(15, 80), 40, 5);
      en = 1'b0;
      drive_random($urandom_range(1, 5), 50, 5);
      en = 1'b1;
    end
    drive_random(250, 100, 0);
    drive_random(200, 15, 2);
    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rsti = 1'b0;
    #1 check_reset_values("async_reset");
    drive_random(3, 50, 0);
    @(negedge clk);
    rsti = 1'b1;
    drive_random(250, 30, 3);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
